// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the 8-entry byte FIFO and sends each byte as a UART frame
// on tx, LSB first (start, 8 data bits, optional parity, stop).
// The frame is 8N1 by default. Define FIFO_UART_TX_PARITY_EN to add an even-parity
// bit after the data bits, which makes the frame 11 bits long.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle high; pop the FIFO when enabled and non-empty
// S_LOAD   | popped byte is on fifo_data; capture it into the shift reg
// S_START  | start bit (tx=0) for CLKS_PER_BIT cycles
// S_DATA   | data bits 0..7, shift_q[0] driven, shift right per bit
// S_PARITY | even parity bit (only with FIFO_UART_TX_PARITY_EN)
// S_STOP   | stop bit (tx=1); frame_done on its last cycle
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   assign bit_end = (baud_q == BAUD_LAST);

   // State, baud timer, bit index and shift register, with a synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Next state and outputs. The outputs are decoded from the state, so tx goes
   // low in the cycle after LOAD. The pop strobe also depends on rst, so that no
   // pop can occur in the same cycle that reset is asserted.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q + 16'd1;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      fifo_rd_en = 1'b0;
      tx         = 1'b1;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy   = 1'b0;
            baud_d = '0;
            if (enable && !fifo_empty && !rst) begin
               fifo_rd_en = 1'b1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            shift_d   = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d  = ^fifo_data;
`endif
            bit_idx_d = '0;
            baud_d    = '0;
            state_d   = S_START;
         end
         S_START: begin
            tx = 1'b0;
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx = shift_q[0];
            if (bit_end) begin
               baud_d    = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            tx = parity_q;
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               frame_done = 1'b1;
               baud_d     = '0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
